// File: rtl/sr_excitation_driver.sv
// rtl/sr_excitation_driver.sv - S/R input sequencer and self-checker for an external set-reset flop
module sr_excitation_driver #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 4,
  parameter int MIN_EXC = 1,
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic             q_in,
  output logic             s_out,
  output logic             r_out,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [IDX_W-1:0] bit_idx
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_HOLD,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] pat_q;
  logic             d;
  logic             last_bit;
  logic             s_nx;
  logic             r_nx;

  assign d        = pat_q[bit_idx];
  assign last_bit = (bit_idx == IDX_W'(WIDTH - 1));
  assign busy     = (state == ST_DRIVE) || (state == ST_HOLD) || (state == ST_CHECK);
  assign done     = (state == ST_DONE);

  // Minimal mode only pulses the input that actually moves q; forced mode always drives.
  always_comb begin
    s_nx = 1'b0;
    r_nx = 1'b0;
    if (MIN_EXC != 0) begin
      s_nx = d & ~q_in;
      r_nx = ~d & q_in;
    end else begin
      s_nx = d;
      r_nx = ~d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_DRIVE;
      ST_DRIVE: state_nx = ST_HOLD;
      ST_HOLD:  state_nx = ST_CHECK;
      ST_CHECK: state_nx = last_bit ? ST_DONE : ST_DRIVE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Drive outputs default low each cycle, so s/r are only high during HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_out    <= 1'b0;
      r_out    <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
      bit_idx  <= '0;
      pat_q    <= '0;
    end else begin
      s_out    <= 1'b0;
      r_out    <= 1'b0;
      mismatch <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pat_q   <= pattern;
            bit_idx <= '0;
            err_cnt <= '0;
          end
        end
        ST_DRIVE: begin
          s_out <= s_nx;
          r_out <= r_nx;
        end
        ST_CHECK: begin
          if (q_in != d) begin
            mismatch <= 1'b1;
            if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
          end
          if (!last_bit) bit_idx <= bit_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sr_excitation_driver.md
Name: sr_excitation_driver

Overview:
- Drives the S/R input pair of an external set-reset flip-flop so its state follows a loaded WIDTH-bit target pattern, one bit per step, LSB first.
- Checks the flop output after every step and counts mismatches.
- Acts as the initiator/stimulus end of the SR flop interface. Used as a built-in sequencer/self-checker for SR storage cells in the behavioural library.

Parameters:
- WIDTH, 8, target pattern length in bits.
- CNT_W, 4, mismatch counter width; the counter saturates at 2^CNT_W-1.
- MIN_EXC, 1, excitation mode:
  - 1 = minimal excitation (assert S or R only when q must change).
  - 0 = forced excitation (always assert S for a target 1, R for a target 0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to run a sequence; sampled only in IDLE.
- pattern  input  WIDTH  target sequence; captured on the accepted start.
- q_in  input  1  feedback from the driven flop's q.
- s_out  output  1  set drive to the flop (registered).
- r_out  output  1  reset drive to the flop (registered).
- busy  output  1  high while a sequence is in progress (DRIVE/HOLD/CHECK).
- done  output  1  one-cycle pulse when the sequence completes.
- mismatch  output  1  one-cycle pulse after a failed check.
- err_cnt  output  CNT_W  saturating mismatch count for the current or last run.
- bit_idx  output  $clog2(WIDTH)  index of the bit being driven or checked.

Behaviour:

Reset:
- rst has priority over all other inputs.
- s_out, r_out, busy, done, mismatch, err_cnt and bit_idx are all 0; state is IDLE.
- rst asserted mid-sequence aborts the run with no done pulse, and s_out/r_out are 0 from the next cycle.

State machine (IDLE, DRIVE, HOLD, CHECK, DONE):
- IDLE: s_out=r_out=0. If start=1 at edge E0: latch pattern into a shadow register, bit_idx=0, err_cnt=0, go to DRIVE.
- DRIVE: d = pat[bit_idx].
  - MIN_EXC=1: s_out = d & ~q_in, r_out = ~d & q_in.
  - MIN_EXC=0: s_out = d, r_out = ~d.
  - Go to HOLD.
- HOLD: s_out/r_out stay stable for the whole cycle so the flop samples them at the edge ending HOLD. At that edge s_out=r_out=0; go to CHECK.
- CHECK: at the edge ending CHECK, compare q_in with d.
  - On inequality: mismatch=1 for the next cycle, and err_cnt increments unless already at its maximum.
  - If bit_idx==WIDTH-1, go to DONE; otherwise bit_idx+1 and go to DRIVE.
- DONE: busy=0, done=1 for exactly this cycle; go to IDLE at the next edge. err_cnt holds until the next accepted start.

Timing:
- Each bit takes 3 cycles.
- busy rises after E0.
- The check of bit k occurs at edge E0+3(k+1).
- done is high during the cycle following E0+3*WIDTH.
- A new start is accepted on the edge ending IDLE, so back-to-back runs have at least 1 idle cycle.

Invariants:
- s_out & r_out is never 1 in any state or mode; the forbidden SR input combination is never driven.
- s_out and r_out are 0 in IDLE, CHECK and DONE.
- start while busy or in DONE is ignored; the pattern is not re-captured.
- Changes on pattern after capture have no effect.
- q_in unknown (X) in DRIVE with MIN_EXC=1 propagates X to s_out/r_out. The bench must reset the flop before start.

Test Plan:
1. Hold rst 2 cycles with start=1 -> s_out=r_out=busy=done=mismatch=0, err_cnt=0, state IDLE; no start accepted.
2. WIDTH=8, MIN_EXC=1, flop reset to 0, pattern=8'b1010_0110, start for 1 cycle -> s/r follow LSB-first bits 0,1,1,0,0,1,0,1; err_cnt=0; done pulse at E0+24; busy high exactly 24 cycles; s_out&r_out never 1.
3. q_in tied to 0, pattern=8'hFF -> 8 mismatch pulses at E0+3,6,...,24 (+1 cycle); err_cnt=8.
4. MIN_EXC=1, flop at 0, pattern=8'h00 -> s_out and r_out never asserted, err_cnt=0. Repeat with MIN_EXC=0 -> r_out high in each HOLD-phase cycle (8 pulses), s_out never asserted.
5. Start run, pulse start again at bit 2 -> ignored. Assert rst during bit 3 HOLD -> next cycle s_out=r_out=0, busy=0, err_cnt=0, no done pulse.
6. CNT_W=3, q_in tied to 0, pattern=8'hFF -> err_cnt saturates at 7 while mismatch still pulses 8 times.
